comm_link_channel: RTL



---
 rtl/comm_link_pkg.sv | 16 +
 rtl/sync_stages.sv | 15 +
 rtl/comm_link_channel.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/comm_link_pkg.sv
// comm_link_pkg: register map, status bit indices and FSM encodings shared by the comm link channel.
package comm_link_pkg;
    localparam logic [1:0] ADDR_TX_DATA  = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_RX_DATA  = 2'd2;
    localparam logic [1:0] ADDR_LINK_RAW = 2'd3;
    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_IRQ_EN     = 3;
    typedef enum logic [1:0] {TX_IDLE, TX_DRIVE, TX_WAIT_ACK, TX_WAIT_REL} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT_REL} rx_state_t;
    function automatic int beats(input int word_w, input int lane_w);
        return word_w / lane_w;
    endfunction
endpackage

// File: rtl/sync_stages.sv
// sync_stages: DEPTH-flop synchroniser for one asynchronous link input.
module sync_stages #(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] s;
    always_ff @(posedge clock or posedge reset)
        if (reset) s <= '0;
        else s <= {s[DEPTH-2:0], d};
    assign q = s[DEPTH-1];
endmodule

// File: rtl/comm_link_channel.sv
// comm_link_channel: CPU word registers carried over a narrow GPIO link with a four-phase req/ack handshake.
// Optional COMM_LINK_IRQ_EN adds an irq output and the STATUS irq_en bit.
module comm_link_channel
    import comm_link_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int LANE_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              write,
    input  logic              read,
    input  logic [WORD_W-1:0] data_write,
    output logic [WORD_W-1:0] data_read,
    output logic [LANE_W-1:0] tx_lane,
    output logic              tx_req,
    input  logic              tx_ack_in,
    input  logic [LANE_W-1:0] rx_lane,
    input  logic              rx_req_in,
    output logic              rx_ack
`ifdef COMM_LINK_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int BEATS = beats(WORD_W, LANE_W);
    localparam int BW    = $clog2(BEATS + 1);

    logic ack_s, req_s, req_q;
    tx_state_t tx_state, tx_state_n;
    rx_state_t rx_state, rx_state_n;
    logic [WORD_W-1:0] tx_shift, tx_shift_n, rx_asm, rx_asm_n, rx_data;
    logic [BW-1:0] tx_beat, tx_beat_n, rx_beat, rx_beat_n;
    logic [LANE_W-1:0] tx_lane_n;
    logic tx_req_n, tx_busy, tx_busy_n, rx_ack_n, rx_valid, rx_overrun, done, irq_en;
    logic wr_tx, rd_rx, tx_last, rx_last;

    sync_stages #(.DEPTH(SYNC_STAGES)) u_ack_sync (.clock(clock), .reset(reset), .d(tx_ack_in), .q(ack_s));
    sync_stages #(.DEPTH(SYNC_STAGES)) u_req_sync (.clock(clock), .reset(reset), .d(rx_req_in), .q(req_s));

    assign wr_tx   = write && address == ADDR_TX_DATA && !tx_busy;
    assign rd_rx   = read && address == ADDR_RX_DATA;
    assign tx_last = tx_beat == BW'(BEATS - 1);
    assign rx_last = rx_beat == BW'(BEATS - 1);

    // tx_req rises one cycle after tx_lane changes, giving the peer a cycle of data setup
    always_comb begin
        tx_state_n = tx_state;
        tx_shift_n = tx_shift;
        tx_beat_n  = tx_beat;
        tx_lane_n  = tx_lane;
        tx_req_n   = tx_req;
        tx_busy_n  = tx_busy;
        case (tx_state)
            TX_IDLE: if (wr_tx) begin
                tx_shift_n = data_write;
                tx_beat_n  = '0;
                tx_busy_n  = 1'b1;
                tx_state_n = TX_DRIVE;
            end
            TX_DRIVE: begin
                tx_lane_n  = tx_shift[LANE_W-1:0];
                tx_state_n = TX_WAIT_ACK;
            end
            TX_WAIT_ACK: begin
                tx_req_n   = ~ack_s;
                tx_state_n = ack_s ? TX_WAIT_REL : TX_WAIT_ACK;
            end
            TX_WAIT_REL: if (!ack_s) begin
                tx_shift_n = tx_shift >> LANE_W;
                tx_beat_n  = tx_last ? '0 : tx_beat + 1'b1;
                tx_busy_n  = !tx_last;
                tx_state_n = tx_last ? TX_IDLE : TX_DRIVE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_asm_n   = rx_asm;
        rx_beat_n  = rx_beat;
        rx_ack_n   = rx_ack;
        done       = 1'b0;
        case (rx_state)
            RX_IDLE: if (req_s && !req_q) begin
                rx_asm_n   = {rx_lane, rx_asm[WORD_W-1:LANE_W]};
                rx_ack_n   = 1'b1;
                rx_state_n = RX_ACK;
            end
            RX_ACK: rx_state_n = RX_WAIT_REL;
            RX_WAIT_REL: if (!req_s) begin
                rx_ack_n   = 1'b0;
                rx_beat_n  = rx_last ? '0 : rx_beat + 1'b1;
                done       = rx_last;
                rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            rx_state   <= RX_IDLE;
            tx_shift   <= '0;
            tx_beat    <= '0;
            tx_lane    <= '0;
            tx_req     <= 1'b0;
            tx_busy    <= 1'b0;
            rx_asm     <= '0;
            rx_beat    <= '0;
            rx_ack     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            req_q      <= 1'b0;
            data_read  <= '0;
        end else begin
            tx_state   <= tx_state_n;
            rx_state   <= rx_state_n;
            tx_shift   <= tx_shift_n;
            tx_beat    <= tx_beat_n;
            tx_lane    <= tx_lane_n;
            tx_req     <= tx_req_n;
            tx_busy    <= tx_busy_n;
            rx_asm     <= rx_asm_n;
            rx_beat    <= rx_beat_n;
            rx_ack     <= rx_ack_n;
            req_q      <= req_s;
            rx_data    <= done ? rx_asm : rx_data;
            // completion beats a simultaneous RX_DATA read: valid stays set, overrun is not raised
            rx_valid   <= done | (rx_valid & ~rd_rx);
            rx_overrun <= ~rd_rx & (rx_overrun | (done & rx_valid));
            data_read  <= !read ? data_read :
                          address == ADDR_STATUS   ? WORD_W'({irq_en, rx_overrun, rx_valid, tx_busy}) :
                          address == ADDR_RX_DATA  ? rx_data :
                          address == ADDR_LINK_RAW ? WORD_W'({req_s, ack_s, rx_lane}) : '0;
        end
    end

`ifdef COMM_LINK_IRQ_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= (write && address == ADDR_STATUS) ? data_write[ST_IRQ_EN] : irq_en;
            irq    <= irq_en & (rx_valid | ~tx_busy);
        end
    end
`else
    assign irq_en = 1'b0;
`endif
endmodule
